// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the 7-segment display scan scheduler.
// Imported by the decoder and the scheduler top.
package display_pkg;

  // Page FSM: the two show states plus a settle state in front of each one.
  typedef enum logic [1:0] {
    TIME     = 2'd0,
    DATE_SET = 2'd1,
    DATE     = 2'd2,
    TIME_SET = 2'd3
  } page_state_e;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Active-low one-hot anode pattern for digit idx.
  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Bus between the frame builder / control side and the scan scheduler.
// When DSCAN_BRIGHT_EN is defined the bus also carries the 3-bit brightness level.
interface display_scan_scheduler_if;
  logic        en;
  logic        btn_page;
  logic [39:0] frame_i;
  logic        display_year;
  logic [7:0]  an;
  logic [7:0]  seg;
`ifdef DSCAN_BRIGHT_EN
  logic [2:0]  bright;

  modport master (output en, btn_page, frame_i, bright, input display_year, an, seg);
  modport slave  (input en, btn_page, frame_i, bright, output display_year, an, seg);
`else
  modport master (output en, btn_page, frame_i, input display_year, an, seg);
  modport slave  (input en, btn_page, frame_i, output display_year, an, seg);
`endif
endinterface

// File: rtl/display_scan_scheduler_seg7_decode.sv
// Combinational 7-segment decoder: 4-bit code plus dp to active-low {dp,g,f,e,d,c,b,a}.
// Codes 0-9 are digits, CODE_DASH lights only g, everything else is blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] pattern;

  // Map the code to an active-high gfedcba pattern, then invert for the pins.
  always_comb begin
    pattern = 7'h00;
    case (code)
      4'd0:      pattern = 7'h3F;
      4'd1:      pattern = 7'h06;
      4'd2:      pattern = 7'h5B;
      4'd3:      pattern = 7'h4F;
      4'd4:      pattern = 7'h66;
      4'd5:      pattern = 7'h6D;
      4'd6:      pattern = 7'h7D;
      4'd7:      pattern = 7'h07;
      4'd8:      pattern = 7'h7F;
      4'd9:      pattern = 7'h6F;
      CODE_DASH: pattern = 7'h40;
      default:   pattern = 7'h00;
    endcase
    seg = ~{dp, pattern};
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// 8-digit 7-segment scan scheduler with time/date page rotation.
// Optional build macro DSCAN_BRIGHT_EN adds PWM brightness via bus.bright.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int TIME_SHOW_S = 10,
  parameter int DATE_SHOW_S = 3,
  parameter int PAGE_LAT    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  display_scan_scheduler_if.slave  bus
);

  localparam int SLOT      = CLK_HZ / SCAN_HZ;
  localparam int SLOT_W    = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DWELL_MAX = ((TIME_SHOW_S > DATE_SHOW_S) ? TIME_SHOW_S : DATE_SHOW_S) - 1;
  localparam int DWELL_W   = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;
  localparam int SETTLE_W  = (PAGE_LAT > 1) ? $clog2(PAGE_LAT) : 1;

  localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(SLOT - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(CLK_HZ - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(PAGE_LAT - 1);
  localparam logic [DWELL_W-1:0]  TIME_LIM    = DWELL_W'(TIME_SHOW_S - 1);
  localparam logic [DWELL_W-1:0]  DATE_LIM    = DWELL_W'(DATE_SHOW_S - 1);

  page_state_e         state, state_nxt;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [2:0]          idx;
  logic [39:0]         shadow;
  logic [PRE_W-1:0]    prescaler;
  logic [DWELL_W-1:0]  dwell;
  logic [SETTLE_W-1:0] settle;
  logic [7:0]          an_q, seg_q;

  logic        slot_wrap, sec_tick, in_show, leave, expire, settle_done, lit;
  logic [31:0] codes;
  logic [7:0]  dp_mask;
  logic [3:0]  cur_code;
  logic        cur_dp;
  logic [7:0]  dec_seg;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign sec_tick    = (prescaler == PRE_LAST);
  assign in_show     = (state == TIME) || (state == DATE);
  assign leave       = (state_nxt != state);
  assign settle_done = (settle == SETTLE_LAST);
  assign expire      = sec_tick && (dwell == ((state == DATE) ? DATE_LIM : TIME_LIM));

  assign codes    = shadow[39:8];
  assign dp_mask  = shadow[7:0];
  assign cur_code = codes[{idx, 2'b00} +: 4];
  assign cur_dp   = dp_mask[idx];

  seg7_decode u_decode (
    .code (cur_code),
    .dp   (cur_dp),
    .seg  (dec_seg)
  );

`ifdef DSCAN_BRIGHT_EN
  int lit_len;
  assign lit_len = ((int'(bus.bright) + 1) * SLOT) / 8;
  assign lit     = bus.en && (int'(slot_cnt) < lit_len);
`else
  assign lit = bus.en;
`endif

  // Slot timer and digit index; the scan runs regardless of en or page state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Shadow frame updates only between scans and never while a page is settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (slot_wrap && (idx == 3'd7) && in_show) begin
      shadow <= bus.frame_i;
    end
  end

  // Seconds prescaler and dwell counter restart on every entry to a show state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      dwell     <= '0;
    end else if (!in_show || leave) begin
      prescaler <= '0;
      dwell     <= '0;
    end else if (sec_tick) begin
      prescaler <= '0;
      dwell     <= dwell + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Settle counter measures the frame builder latency after a page switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
    end else if (in_show || settle_done) begin
      settle <= '0;
    end else begin
      settle <= settle + 1'b1;
    end
  end

  // Page FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TIME;
    end else begin
      state <= state_nxt;
    end
  end

  // Page FSM next state; a button and an expiry in the same cycle give one toggle.
  always_comb begin
    state_nxt = state;
    case (state)
      TIME:     if (bus.btn_page || expire) state_nxt = DATE_SET;
      DATE_SET: if (settle_done)            state_nxt = DATE;
      DATE:     if (bus.btn_page || expire) state_nxt = TIME_SET;
      TIME_SET: if (settle_done)            state_nxt = TIME;
      default:                              state_nxt = TIME;
    endcase
  end

  // Registered pin drive; dark whenever the display is disabled or dimmed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= SEG_OFF;
      seg_q <= SEG_OFF;
    end else if (lit) begin
      an_q  <= digit_enable(idx);
      seg_q <= dec_seg;
    end else begin
      an_q  <= SEG_OFF;
      seg_q <= SEG_OFF;
    end
  end

  assign bus.display_year = (state == DATE_SET) || (state == DATE);
  assign bus.an           = an_q;
  assign bus.seg          = seg_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler with an 8-cycle slot and 80-cycle second.
// Edge numbers below count rising clock edges after reset release.
module tb_display_scan_scheduler;

  logic clk;
  logic rst_n;
  int   edge_n;
  int   check_count;
  int   pass_count;
  int   fail_count;

  localparam logic [39:0] FRAME1 = 40'h12A34A5600;
  localparam logic [39:0] FRAME2 = 40'h9876543201;
  localparam logic [39:0] FRAME3 = 40'h073B4FA920;

  display_scan_scheduler_if bus ();

  display_scan_scheduler #(
    .CLK_HZ      (80),
    .SCAN_HZ     (10),
    .TIME_SHOW_S (2),
    .DATE_SHOW_S (1),
    .PAGE_LAT    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic btn, input logic [39:0] frame);
    bus.en       = en;
    bus.btn_page = btn;
    bus.frame_i  = frame;
  endtask

  // Advance to the falling edge that follows rising edge k.
  task automatic runTo(input int k);
    while (edge_n < k) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  // Linear directed sequence; every expected value is hand-derived from the edge count.
  initial begin
    check_count = 0;
    pass_count  = 0;
    fail_count  = 0;
    edge_n      = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 1'b0, FRAME1);
`ifdef DSCAN_BRIGHT_EN
    bus.bright = 3'd7;
`endif

    repeat (5) @(negedge clk);
    checkOutput("reset_an", bus.an, 8'hFF);
    checkOutput("reset_seg", bus.seg, 8'hFF);
    checkOutput("reset_year", {7'd0, bus.display_year}, 8'h00);

    rst_n = 1'b1;
    runTo(1);
    checkOutput("e1_an", bus.an, 8'hFE);
    checkOutput("e1_seg_zero_shadow", bus.seg, 8'hC0);

    runTo(65);
    checkOutput("d0_an", bus.an, 8'hFE);
    checkOutput("d0_seg_6", bus.seg, 8'h82);
    runTo(105);
    checkOutput("d5_an", bus.an, 8'hDF);
    checkOutput("d5_seg_dash", bus.seg, 8'hBF);
    runTo(121);
    checkOutput("d7_an", bus.an, 8'h7F);
    checkOutput("d7_seg_1", bus.seg, 8'hF9);

    runTo(154);
    applyStimulus(1'b1, 1'b0, FRAME2);
    runTo(159);
    checkOutput("year_before_expiry", {7'd0, bus.display_year}, 8'h00);
    runTo(160);
    checkOutput("year_at_expiry", {7'd0, bus.display_year}, 8'h01);
    runTo(162);
    checkOutput("year_date_set", {7'd0, bus.display_year}, 8'h01);

    runTo(169);
    checkOutput("tear_d5_an", bus.an, 8'hDF);
    checkOutput("tear_d5_seg_old", bus.seg, 8'hBF);
    runTo(193);
    checkOutput("new_d0_an", bus.an, 8'hFE);
    checkOutput("new_d0_seg_2dp", bus.seg, 8'h24);

    runTo(242);
    checkOutput("year_date_end", {7'd0, bus.display_year}, 8'h01);
    runTo(243);
    checkOutput("year_date_expired", {7'd0, bus.display_year}, 8'h00);

    runTo(300);
    applyStimulus(1'b1, 1'b0, FRAME3);
    runTo(317);
    checkOutput("year_before_btn", {7'd0, bus.display_year}, 8'h00);
    applyStimulus(1'b1, 1'b1, FRAME3);
    runTo(318);
    applyStimulus(1'b1, 1'b0, FRAME3);
    checkOutput("year_after_btn", {7'd0, bus.display_year}, 8'h01);
    runTo(319);
    applyStimulus(1'b1, 1'b1, FRAME3);
    runTo(320);
    applyStimulus(1'b1, 1'b0, FRAME3);
    checkOutput("year_btn_in_set", {7'd0, bus.display_year}, 8'h01);
    runTo(321);
    checkOutput("frozen_d0_an", bus.an, 8'hFE);
    checkOutput("frozen_d0_seg", bus.seg, 8'h24);
    runTo(330);
    checkOutput("year_btn_ignored", {7'd0, bus.display_year}, 8'h01);

    runTo(385);
    checkOutput("f3_d0_an", bus.an, 8'hFE);
    checkOutput("f3_d0_seg_9", bus.seg, 8'h90);
    runTo(401);
    checkOutput("f3_d2_an", bus.an, 8'hFB);
    checkOutput("f3_d2_seg_blank", bus.seg, 8'hFF);

    runTo(520);
    applyStimulus(1'b0, 1'b0, FRAME3);
    runTo(521);
    checkOutput("dark_an", bus.an, 8'hFF);
    checkOutput("dark_seg", bus.seg, 8'hFF);
    runTo(563);
    checkOutput("dark_year_before", {7'd0, bus.display_year}, 8'h00);
    checkOutput("dark_an_563", bus.an, 8'hFF);
    runTo(564);
    checkOutput("dark_year_toggle", {7'd0, bus.display_year}, 8'h01);
    runTo(600);
    checkOutput("dark_an_600", bus.an, 8'hFF);
    runTo(620);
    checkOutput("dark_an_620", bus.an, 8'hFF);
    applyStimulus(1'b1, 1'b0, FRAME3);
    runTo(621);
    checkOutput("resume_d5_an", bus.an, 8'hDF);
    checkOutput("resume_d5_seg_3dp", bus.seg, 8'h30);

    runTo(630);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_an", bus.an, 8'hFF);
    checkOutput("midrun_reset_seg", bus.seg, 8'hFF);
    checkOutput("midrun_reset_year", {7'd0, bus.display_year}, 8'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
